seq_serializer: RTL and testbench

//  Upstream feeder for the serial sequence detector: accepts parallel words over a

---
 rtl/seq_ser_pkg.sv | 22 ++
 rtl/seq_ser_shreg.sv | 59 +++++
 rtl/seq_serializer.sv | 117 +++++++++++
 tb/tb_seq_serializer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_ser_pkg.sv
// Shared types and sizing helpers for the sequence-detector feeder (seq_serializer).
// Optional feature macro: SER_PARITY_EN appends one even-parity bit to every word.
package seq_ser_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SHIFT = 2'b01,
      S_GAP   = 2'b10
   } state_t;

`ifdef SER_PARITY_EN
   localparam int PARITY_BITS = 1;
`else
   localparam int PARITY_BITS = 0;
`endif

   // Width of a down-counter holding values 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seq_ser_shreg.sv
// Load/shift register for seq_serializer; exposes the head bit of the value being written.
// With SER_PARITY_EN defined the loaded word carries a trailing even-parity bit.
module seq_ser_shreg
   import seq_ser_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] data_in,
   output logic             head_next
);

   localparam int NBITS = WIDTH + PARITY_BITS;

   logic [NBITS-1:0] shreg;
   logic [NBITS-1:0] shreg_next;
   logic [NBITS-1:0] load_word;

   // The parity bit sits at the far end so it always leaves after the data bits.
   always_comb begin
`ifdef SER_PARITY_EN
      if (MSB_FIRST != 0) begin
         load_word = {data_in, ^data_in};
      end else begin
         load_word = {^data_in, data_in};
      end
`else
      load_word = data_in;
`endif
   end

   always_comb begin
      shreg_next = shreg;
      if (load) begin
         shreg_next = load_word;
      end else if (shift) begin
         if (MSB_FIRST != 0) begin
            shreg_next = {shreg[NBITS-2:0], 1'b0};
         end else begin
            shreg_next = {1'b0, shreg[NBITS-1:1]};
         end
      end
   end

   assign head_next = (MSB_FIRST != 0) ? shreg_next[NBITS-1] : shreg_next[0];

   always_ff @(posedge clock) begin
      if (reset) begin
         shreg <= '0;
      end else begin
         shreg <= shreg_next;
      end
   end

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial feeder for the sequence detector: valid/ready word input, one bit per clock out.
// Optional feature macro: SER_PARITY_EN (even-parity bit after each word, NBITS = WIDTH+1).
module seq_serializer
   import seq_ser_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int GAP_CYCLES = 0,
   parameter int MSB_FIRST  = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   output logic             seq_out,
   output logic             seq_valid,
   output logic             busy,
   output logic             word_done
);

   localparam int NBITS = WIDTH + PARITY_BITS;
   localparam int BIT_W = cnt_width(NBITS);
   localparam int GAP_W = cnt_width(GAP_CYCLES);
   localparam bit BACK_TO_BACK = (GAP_CYCLES == 0);

   state_t           state;
   state_t           state_next;
   logic [BIT_W-1:0] bitcnt;
   logic [BIT_W-1:0] bitcnt_next;
   logic [GAP_W-1:0] gapcnt;
   logic [GAP_W-1:0] gapcnt_next;
   logic             last_bit;
   logic             accept;
   logic             load;
   logic             shift;
   logic             head_next;

   seq_ser_shreg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shreg (
      .clock     (clock),
      .reset     (reset),
      .load      (load),
      .shift     (shift),
      .data_in   (data_in),
      .head_next (head_next)
   );

   // Without a gap, the last bit cycle doubles as an accept window for a seamless stream.
   assign last_bit   = (state == S_SHIFT) && (bitcnt == '0);
   assign data_ready = !reset && ((state == S_IDLE) || (BACK_TO_BACK && last_bit));
   assign accept     = data_valid && data_ready;

   always_comb begin
      state_next  = state;
      bitcnt_next = bitcnt;
      gapcnt_next = gapcnt;
      load        = 1'b0;
      shift       = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (accept) begin
               load        = 1'b1;
               bitcnt_next = BIT_W'(NBITS - 1);
               state_next  = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (bitcnt != '0) begin
               shift       = 1'b1;
               bitcnt_next = bitcnt - BIT_W'(1);
            end else if (accept) begin
               load        = 1'b1;
               bitcnt_next = BIT_W'(NBITS - 1);
            end else if (GAP_CYCLES > 0) begin
               gapcnt_next = GAP_W'(GAP_CYCLES - 1);
               state_next  = S_GAP;
            end else begin
               state_next  = S_IDLE;
            end
         end
         S_GAP: begin
            if (gapcnt == '0) begin
               state_next  = S_IDLE;
            end else begin
               gapcnt_next = gapcnt - GAP_W'(1);
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Outputs are registered from the next-state values so they line up with the state they describe.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= S_IDLE;
         bitcnt    <= '0;
         gapcnt    <= '0;
         seq_out   <= 1'b0;
         seq_valid <= 1'b0;
         busy      <= 1'b0;
         word_done <= 1'b0;
      end else begin
         state     <= state_next;
         bitcnt    <= bitcnt_next;
         gapcnt    <= gapcnt_next;
         seq_out   <= (state_next == S_SHIFT) && head_next;
         seq_valid <= (state_next == S_SHIFT);
         busy      <= (state_next != S_IDLE);
         word_done <= (state_next == S_SHIFT) && (bitcnt_next == '0);
      end
   end

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: a GAP_CYCLES=0 MSB-first instance and a GAP_CYCLES=2 LSB-first instance.
// Honours SER_PARITY_EN when the design is built with it.
module tb_seq_serializer;

`ifdef SER_PARITY_EN
   localparam int NB = 9;
`else
   localparam int NB = 8;
`endif
   localparam int NV = 7;

   typedef struct {
      logic [7:0] word;
      logic [0:7] msb_seq;
      logic [0:7] lsb_seq;
      logic       par;
   } vec_t;

   vec_t vecs [NV];

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] a_data, b_data;
   logic       a_valid, b_valid;
   logic       a_ready, a_seq_out, a_seq_valid, a_busy, a_word_done;
   logic       b_ready, b_seq_out, b_seq_valid, b_busy, b_word_done;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   seq_serializer #(.WIDTH(8), .GAP_CYCLES(0), .MSB_FIRST(1)) dut_a (
      .clock      (clock),
      .reset      (reset),
      .data_in    (a_data),
      .data_valid (a_valid),
      .data_ready (a_ready),
      .seq_out    (a_seq_out),
      .seq_valid  (a_seq_valid),
      .busy       (a_busy),
      .word_done  (a_word_done)
   );

   seq_serializer #(.WIDTH(8), .GAP_CYCLES(2), .MSB_FIRST(0)) dut_b (
      .clock      (clock),
      .reset      (reset),
      .data_in    (b_data),
      .data_valid (b_valid),
      .data_ready (b_ready),
      .seq_out    (b_seq_out),
      .seq_valid  (b_seq_valid),
      .busy       (b_busy),
      .word_done  (b_word_done)
   );

   task automatic checkOutput(input string name, input logic actual, input logic expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic av, input logic [7:0] ad,
                                input logic bv, input logic [7:0] bd);
      a_valid = av;
      a_data  = ad;
      b_valid = bv;
      b_data  = bd;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic exp_bit(input int v, input int i, input bit msb);
      if (i >= 8) return vecs[v].par;
      return msb ? vecs[v].msb_seq[i] : vecs[v].lsb_seq[i];
   endfunction

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Expected streams listed in transmission order (index 0 leaves first).
      vecs[0] = '{8'h0B, 8'b0000_1011, 8'b1101_0000, 1'b1};
      vecs[1] = '{8'hA5, 8'b1010_0101, 8'b1010_0101, 1'b0};
      vecs[2] = '{8'h3C, 8'b0011_1100, 8'b0011_1100, 1'b0};
      vecs[3] = '{8'h80, 8'b1000_0000, 8'b0000_0001, 1'b1};
      vecs[4] = '{8'h6E, 8'b0110_1110, 8'b0111_0110, 1'b1};
      vecs[5] = '{8'hFF, 8'b1111_1111, 8'b1111_1111, 1'b0};
      vecs[6] = '{8'h07, 8'b0000_0111, 8'b1110_0000, 1'b1};

      reset = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
      step();
      step();
      checkOutput("rst_a_seq_out",   a_seq_out,   1'b0);
      checkOutput("rst_a_seq_valid", a_seq_valid, 1'b0);
      checkOutput("rst_a_busy",      a_busy,      1'b0);
      checkOutput("rst_a_word_done", a_word_done, 1'b0);
      checkOutput("rst_a_ready",     a_ready,     1'b0);
      checkOutput("rst_b_seq_valid", b_seq_valid, 1'b0);
      checkOutput("rst_b_ready",     b_ready,     1'b0);
      reset = 1'b0;
      #1;
      checkOutput("post_rst_a_ready", a_ready, 1'b1);
      checkOutput("post_rst_b_ready", b_ready, 1'b1);

      // Back-to-back stream on the gapless instance, data_valid held throughout.
      applyStimulus(1'b1, vecs[0].word, 1'b0, 8'h00);
      step();
      for (int v = 0; v < NV; v++) begin
         for (int i = 0; i < NB; i++) begin
            checkOutput("a_seq_out",   a_seq_out,   exp_bit(v, i, 1'b1));
            checkOutput("a_seq_valid", a_seq_valid, 1'b1);
            checkOutput("a_busy",      a_busy,      1'b1);
            checkOutput("a_word_done", a_word_done, i == NB - 1);
            checkOutput("a_ready",     a_ready,     i == NB - 1);
            if (i == NB - 1) begin
               if (v == NV - 1) a_valid = 1'b0;
               else a_data = vecs[v + 1].word;
            end else begin
               a_data = 8'($urandom);
            end
            step();
         end
      end
      checkOutput("a_end_seq_valid", a_seq_valid, 1'b0);
      checkOutput("a_end_seq_out",   a_seq_out,   1'b0);
      checkOutput("a_end_busy",      a_busy,      1'b0);
      checkOutput("a_end_ready",     a_ready,     1'b1);

      // Gapped LSB-first instance: two idle-zero cycles then one IDLE cycle between words.
      applyStimulus(1'b0, 8'h00, 1'b1, vecs[0].word);
      step();
      for (int v = 0; v < NV; v++) begin
         for (int i = 0; i < NB; i++) begin
            checkOutput("b_seq_out",   b_seq_out,   exp_bit(v, i, 1'b0));
            checkOutput("b_seq_valid", b_seq_valid, 1'b1);
            checkOutput("b_word_done", b_word_done, i == NB - 1);
            checkOutput("b_ready",     b_ready,     1'b0);
            if (i == NB - 1) begin
               if (v == NV - 1) b_valid = 1'b0;
               else b_data = vecs[v + 1].word;
            end else begin
               b_data = 8'($urandom);
            end
            step();
         end
         for (int g = 0; g < 2; g++) begin
            checkOutput("b_gap_seq_valid", b_seq_valid, 1'b0);
            checkOutput("b_gap_seq_out",   b_seq_out,   1'b0);
            checkOutput("b_gap_ready",     b_ready,     1'b0);
            checkOutput("b_gap_busy",      b_busy,      1'b1);
            checkOutput("b_gap_word_done", b_word_done, 1'b0);
            step();
         end
         checkOutput("b_idle_ready",     b_ready,     1'b1);
         checkOutput("b_idle_busy",      b_busy,      1'b0);
         checkOutput("b_idle_seq_valid", b_seq_valid, 1'b0);
         step();
      end

      // Idle with toggling data and no valid: nothing may start.
      for (int c = 0; c < 20; c++) begin
         applyStimulus(1'b0, 8'($urandom), 1'b0, 8'($urandom));
         step();
         checkOutput("idle_a_seq_valid", a_seq_valid, 1'b0);
         checkOutput("idle_a_busy",      a_busy,      1'b0);
         checkOutput("idle_a_word_done", a_word_done, 1'b0);
         checkOutput("idle_b_seq_valid", b_seq_valid, 1'b0);
         checkOutput("idle_b_busy",      b_busy,      1'b0);
         checkOutput("idle_b_word_done", b_word_done, 1'b0);
      end

      // Reset while the fourth bit of 8'hFF is on the wire.
      applyStimulus(1'b1, 8'hFF, 1'b0, 8'h00);
      step();
      a_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checkOutput("mid_a_seq_out", a_seq_out, 1'b1);
         step();
      end
      checkOutput("mid_a_bit4", a_seq_out, 1'b1);
      reset = 1'b1;
      step();
      checkOutput("midrst_seq_valid", a_seq_valid, 1'b0);
      checkOutput("midrst_seq_out",   a_seq_out,   1'b0);
      checkOutput("midrst_busy",      a_busy,      1'b0);
      checkOutput("midrst_word_done", a_word_done, 1'b0);
      checkOutput("midrst_ready",     a_ready,     1'b0);
      reset = 1'b0;
      #1;
      checkOutput("postrst_ready", a_ready, 1'b1);
      for (int i = 0; i < NB; i++) begin
         step();
         checkOutput("postrst_seq_valid", a_seq_valid, 1'b0);
         checkOutput("postrst_word_done", a_word_done, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
